key_history_display: RTL and testbench
======================================

Name: key_history_display

Overview:
- Downstream consumer of the keypad scanner/decoder path.
- Captures each decoded key as a single-cycle strobe and keeps the two most recent keys.
- Time-multiplexes both digits onto the shared seven-segment bus, driving the two display enables.
- Sits between keypad_decoder/press logic and the physical on1/on2/seg pins. Replaces the single-digit latch and constant enables at top level.

Parameters:
- REFRESH_DIV, 20: clk cycles each digit is shown per slot. Must be >= 1. At 10 kHz LSOSC this gives about 227 Hz per display with default BLANK_CYCLES.
- BLANK_CYCLES, 2: clk cycles both enables are low between slots (anti-ghosting). 0 removes the blank states entirely.

Ports:
- clk  in  1  system clock (LSOSC int_osc)
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  single-cycle strobe: new key available
- key  in  4  hex value of pressed key, sampled only when key_valid=1
- seg  out  7  segment drive, active-low, shared by both displays
- on1  out  1  enable, display showing the newer digit, active-high
- on2  out  1  enable, display showing the older digit, active-high

Behaviour:
- All logic clocked on posedge clk. Reset is sampled only on a clk edge and is active-high.
- Reset values:
  - state=SHOW_NEW, cnt=0
  - new_digit=0, old_digit=0
  - new_vld=0, old_vld=0
  - on1=0, on2=0, seg=7'b1111111 (all off)
- History shift: on an edge with key_valid=1:
  - old_digit<=new_digit, old_vld<=new_vld
  - new_digit<=key, new_vld<=1
- Only one key can be accepted per cycle. A key_valid held high for N cycles shifts N times; upstream guarantees a pulse.
- FSM states: SHOW_NEW -> BLANK_A -> SHOW_OLD -> BLANK_B -> SHOW_NEW.
  - SHOW_x lasts REFRESH_DIV cycles; BLANK_x lasts BLANK_CYCLES cycles.
  - cnt is $clog2(max(REFRESH_DIV,BLANK_CYCLES,2)) bits. It counts 0..dur-1, then wraps to 0 on state change.
  - If BLANK_CYCLES=0: SHOW_NEW <-> SHOW_OLD directly.
- Outputs are registered and reflect the state and digit registers of the previous cycle, so there is exactly 1 cycle of latency.
  - SHOW_NEW: on1=1, on2=0, seg=enc(new_digit) if new_vld else 7'b1111111.
  - SHOW_OLD: on1=0, on2=1, seg=enc(old_digit) if old_vld else 7'b1111111.
  - BLANK_x: on1=0, on2=0, seg=7'b1111111.
  - on1 and on2 are never simultaneously 1, in any cycle including reset exit.
- Key strobe while its slot is active: if key_valid is accepted at edge T during SHOW_NEW, seg shows the new value from edge T+1. There is no glitch value in between.
- Key strobe during BLANK or the other slot: the digit registers update immediately; the new value appears the first cycle its slot is driven.
- Key strobe coincident with a slot boundary: both the state transition and the shift happen on the same edge. Output at T+1 uses the post-shift digits for the new state.
- Reset mid-slot or coinciding with key_valid: reset wins. The key is discarded and all registers take their reset values.
- First SHOW_NEW after reset: on1 rises 1 cycle after reset deasserts; displays stay blank until a key arrives.
- Encoding enc() is the team's existing hex seven-segment map (0-F), active-low.

Decomposition:
- Shared package lab3_pkg:
  - enum typedef disp_state_t {SHOW_NEW, BLANK_A, SHOW_OLD, BLANK_B}
  - constant SEG_BLANK = 7'b1111111
- Sub-module: reuse the existing seven_segment decoder. Instantiate it once, fed by a digit mux; its output is registered in this block.
- Refresh counter and FSM stay inline. The expected implementation is about 150 lines.

Test Plan:
- Reset hold 3 cycles, release -> on1=on2=0 during reset; cycle after release on1=1, seg=7'b1111111; blank slots and on2 slot also 7'b1111111.
- key_valid pulse key=4'h5, then pulse key=4'hA -> SHOW_NEW seg=enc(A), SHOW_OLD seg=enc(5). Slot timing: on1 high 20 cycles, both low 2, on2 high 20, both low 2; period 44.
- Three pulses 1, 2, 3 spaced 7 cycles -> new=3, old=2; digit 1 is discarded.
- key_valid with key=4'hF on the last cycle of SHOW_NEW -> next cycle is BLANK_A (both enables 0, seg blank). The following SHOW_OLD shows the pre-F newer digit.
- reset asserted together with key_valid (key=4'h7) mid SHOW_OLD -> next cycle all reset values; key 7 never displayed.
- BLANK_CYCLES=0, REFRESH_DIV=1 -> on1/on2 alternate every cycle; assert never both 1; seg changes same cycle as enable.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared types and constants for the keypad display path.
package lab3_pkg;

   localparam int unsigned KEY_W = 4;
   localparam int unsigned SEG_W = 7;

   typedef enum logic [1:0] {
      SHOW_NEW,
      BLANK_A,
      SHOW_OLD,
      BLANK_B
   } disp_state_t;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_history_display_if.sv
// Decoded-key strobe bus from the keypad decoder into the display block.
interface key_history_display_if;
   import lab3_pkg::*;

   logic             key_valid;
   logic [KEY_W-1:0] key;

   modport master (output key_valid, output key);
   modport slave  (input  key_valid, input  key);

endinterface

// File: rtl/seven_segment.sv
// Hex digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_segment
   import lab3_pkg::*;
(
   input  logic [KEY_W-1:0] digit,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (digit)
         4'h0: seg_c = 7'b1000000;
         4'h1: seg_c = 7'b1111001;
         4'h2: seg_c = 7'b0100100;
         4'h3: seg_c = 7'b0110000;
         4'h4: seg_c = 7'b0011001;
         4'h5: seg_c = 7'b0010010;
         4'h6: seg_c = 7'b0000010;
         4'h7: seg_c = 7'b1111000;
         4'h8: seg_c = 7'b0000000;
         4'h9: seg_c = 7'b0010000;
         4'hA: seg_c = 7'b0001000;
         4'hB: seg_c = 7'b0000011;
         4'hC: seg_c = 7'b1000110;
         4'hD: seg_c = 7'b0100001;
         4'hE: seg_c = 7'b0000110;
         4'hF: seg_c = 7'b0001110;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/key_history_display.sv
// Keeps the two most recent keypad digits and time-multiplexes them onto
// the shared seven-segment bus with two active-high display enables.
module key_history_display
   import lab3_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 20,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   key_history_display_if.slave  key_bus,
   output logic [SEG_W-1:0]      seg,
   output logic                  on1,
   output logic                  on2
);

   localparam int unsigned CNT_W      = $clog2(max3(REFRESH_DIV, BLANK_CYCLES, 2));
   localparam int unsigned SHOW_LAST  = REFRESH_DIV - 1;
   localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);

   disp_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] new_digit;
   logic [KEY_W-1:0] old_digit;
   logic             new_vld;
   logic             old_vld;

   logic [KEY_W-1:0] mux_digit_c;
   logic [SEG_W-1:0] dec_seg_c;
   logic             slot_done_c;

   // Single decoder shared by both slots; the mux follows the current state.
   always_comb begin
      mux_digit_c = (state == SHOW_OLD) ? old_digit : new_digit;
   end

   seven_segment u_seven_segment (
      .digit (mux_digit_c),
      .seg_c (dec_seg_c)
   );

   always_comb begin
      slot_done_c = 1'b0;
      if (state == SHOW_NEW || state == SHOW_OLD) begin
         slot_done_c = (cnt == CNT_W'(SHOW_LAST));
      end else begin
         slot_done_c = (cnt == CNT_W'(BLANK_LAST));
      end
   end

   // Refresh FSM, key history and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SHOW_NEW;
         cnt       <= '0;
         new_digit <= '0;
         old_digit <= '0;
         new_vld   <= 1'b0;
         old_vld   <= 1'b0;
         on1       <= 1'b0;
         on2       <= 1'b0;
         seg       <= SEG_BLANK;
      end else begin
         if (key_bus.key_valid) begin
            old_digit <= new_digit;
            old_vld   <= new_vld;
            new_digit <= key_bus.key;
            new_vld   <= 1'b1;
         end

         if (slot_done_c) begin
            cnt <= '0;
            case (state)
               SHOW_NEW: state <= HAS_BLANK ? BLANK_A : SHOW_OLD;
               BLANK_A:  state <= SHOW_OLD;
               SHOW_OLD: state <= HAS_BLANK ? BLANK_B : SHOW_NEW;
               BLANK_B:  state <= SHOW_NEW;
               default:  state <= SHOW_NEW;
            endcase
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // Outputs reflect the state and digits held before this edge.
         on1 <= (state == SHOW_NEW);
         on2 <= (state == SHOW_OLD);
         case (state)
            SHOW_NEW: seg <= new_vld ? dec_seg_c : SEG_BLANK;
            SHOW_OLD: seg <= old_vld ? dec_seg_c : SEG_BLANK;
            default:  seg <= SEG_BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_key_history_display.sv
// Bench for key_history_display: default timing plus a no-blank, 1-cycle-slot variant.
module tb_key_history_display;

   logic       clk;
   logic       reset;
   logic [6:0] seg_a, seg_b;
   logic       on1_a, on2_a, on1_b, on2_b;

   key_history_display_if kbus ();

   key_history_display #(.REFRESH_DIV(20), .BLANK_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .key_bus(kbus.slave),
      .seg(seg_a), .on1(on1_a), .on2(on2_a)
   );

   key_history_display #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .key_bus(kbus.slave),
      .seg(seg_b), .on1(on1_b), .on2(on2_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] BLANK = 7'b1111111;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: slot position from elapsed cycles since reset, history as a 2-deep list.
   int unsigned rdiv[2]  = '{20, 1};
   int unsigned bcyc[2]  = '{2, 0};
   int unsigned t_cnt[2];
   int unsigned pos;
   int          h_cnt[2];
   logic [3:0]  h_new[2];
   logic [3:0]  h_old[2];
   logic [6:0]  exp_seg[2];
   logic        exp_on1[2];
   logic        exp_on2[2];
   bit          mdl_ready = 1'b0;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            t_cnt[d]   = 0;
            h_cnt[d]   = 0;
            exp_on1[d] = 1'b0;
            exp_on2[d] = 1'b0;
            exp_seg[d] = BLANK;
         end else begin
            pos = t_cnt[d] % (2 * rdiv[d] + 2 * bcyc[d]);
            exp_on1[d] = 1'b0;
            exp_on2[d] = 1'b0;
            exp_seg[d] = BLANK;
            if (pos < rdiv[d]) begin
               exp_on1[d] = 1'b1;
               if (h_cnt[d] >= 1) exp_seg[d] = enc(h_new[d]);
            end else if (pos >= rdiv[d] + bcyc[d] && pos < 2 * rdiv[d] + bcyc[d]) begin
               exp_on2[d] = 1'b1;
               if (h_cnt[d] >= 2) exp_seg[d] = enc(h_old[d]);
            end
            t_cnt[d]++;
            if (kbus.key_valid) begin
               h_old[d] = h_new[d];
               h_new[d] = kbus.key;
               if (h_cnt[d] < 2) h_cnt[d]++;
            end
         end
      end
      mdl_ready = 1'b1;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (mdl_ready) begin
         check("seg_a", seg_a, exp_seg[0]);
         check_bit("on1_a", on1_a, exp_on1[0]);
         check_bit("on2_a", on2_a, exp_on2[0]);
         check_bit("excl_a", on1_a & on2_a, 1'b0);
         check("seg_b", seg_b, exp_seg[1]);
         check_bit("on1_b", on1_b, exp_on1[1]);
         check_bit("on2_b", on2_b, exp_on2[1]);
         check_bit("excl_b", on1_b & on2_b, 1'b0);
      end
   end

   task automatic pulse(input logic [3:0] v);
      kbus.key       = v;
      kbus.key_valid = 1'b1;
      @(negedge clk);
      kbus.key_valid = 1'b0;
   endtask

   // Advance until the enable pair of dut_a equals (eq=1) or differs from (eq=0) pat.
   task automatic wait_pat(input logic [1:0] pat, input bit eq);
      int n = 0;
      while ((({on2_a, on1_a} == pat) != eq) && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic sync_to(input string name, input logic [1:0] pat);
      wait_pat(pat, 1'b0);
      wait_pat(pat, 1'b1);
      check_int(name, int'({on2_a, on1_a}), int'(pat));
   endtask

   task automatic run_len(input logic [1:0] pat, output int len);
      len = 0;
      while ({on2_a, on1_a} == pat && len < 100) begin
         len++;
         @(negedge clk);
      end
   endtask

   int   len;
   logic prev;

   initial begin
      reset          = 1'b1;
      kbus.key_valid = 1'b0;
      kbus.key       = 4'h0;
      repeat (3) @(negedge clk);
      check_bit("rst_on1", on1_a, 1'b0);
      check_bit("rst_on2", on2_a, 1'b0);
      check("rst_seg", seg_a, BLANK);
      reset = 1'b0;
      @(negedge clk);
      check_bit("exit_on1", on1_a, 1'b1);
      check("exit_seg", seg_a, BLANK);
      check_bit("exit_on1_b", on1_b, 1'b1);

      // Two keys, then slot timing and contents.
      pulse(4'h5);
      repeat (3) @(negedge clk);
      pulse(4'hA);
      sync_to("sync_new", 2'b01);
      check("new_is_A", seg_a, 7'b0001000);
      run_len(2'b01, len);
      check_int("len_on1", len, 20);
      run_len(2'b00, len);
      check_int("len_blank_a", len, 2);
      check("old_is_5", seg_a, 7'b0010010);
      run_len(2'b10, len);
      check_int("len_on2", len, 20);
      run_len(2'b00, len);
      check_int("len_blank_b", len, 2);

      // Three keys: oldest is dropped.
      pulse(4'h1);
      repeat (6) @(negedge clk);
      pulse(4'h2);
      repeat (6) @(negedge clk);
      pulse(4'h3);
      sync_to("sync_new3", 2'b01);
      check("new_is_3", seg_a, 7'b0110000);
      sync_to("sync_old2", 2'b10);
      check("old_is_2", seg_a, 7'b0100100);

      // Key on the last SHOW_NEW cycle.
      sync_to("sync_last", 2'b01);
      repeat (18) @(negedge clk);
      pulse(4'hF);
      check_bit("last_on1", on1_a, 1'b1);
      @(negedge clk);
      check_bit("bnd_on1", on1_a, 1'b0);
      check_bit("bnd_on2", on2_a, 1'b0);
      check("bnd_seg", seg_a, BLANK);
      sync_to("sync_old3", 2'b10);
      check("old_is_3", seg_a, 7'b0110000);

      // Reset with a coincident key mid SHOW_OLD.
      repeat (5) @(negedge clk);
      reset          = 1'b1;
      kbus.key       = 4'h7;
      kbus.key_valid = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      kbus.key_valid = 1'b0;
      check_bit("rk_on1", on1_a, 1'b0);
      check_bit("rk_on2", on2_a, 1'b0);
      check("rk_seg", seg_a, BLANK);
      check_bit("rk_on1_b", on1_b, 1'b0);
      @(negedge clk);
      check_bit("rk_exit_on1", on1_a, 1'b1);
      check("rk_exit_seg", seg_a, BLANK);
      sync_to("sync_rk_old", 2'b10);
      check("rk_old_blank", seg_a, BLANK);

      // Single key after reset; no-blank variant alternates every cycle.
      pulse(4'h9);
      for (int i = 0; i < 8; i++) begin
         prev = on1_b;
         @(negedge clk);
         check_bit("alt_b", on1_b, ~prev);
         check("alt_seg_b", seg_b, on1_b ? 7'b0010000 : BLANK);
      end
      sync_to("sync_new9", 2'b01);
      check("new_is_9", seg_a, 7'b0010000);
      sync_to("sync_old_blank", 2'b10);
      check("old_blank", seg_a, BLANK);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
